// File: rtl/triangle_channel.sv
// triangle_channel: triangle / sawtooth wave channel with period timer and linear counter.
// Ports:
//   iClk, iReset_n      clock and asynchronous active-low reset
//   iEnable             runs the period timer and the wave sequencer
//   iWrite/iAddr/iWData register writes: 0 = period, 1 = control (reload/mode/halt)
//   iQuarterFrame       clocks the linear counter
//   oData               wave sample
//   oStep               high the cycle after oData took a step
//   oActive             linear counter is nonzero
module triangle_channel #(
    parameter int DATA_WIDTH   = 4,
    parameter int PERIOD_WIDTH = 11,
    parameter int LIN_WIDTH    = 7
) (
    input  logic                  iClk,
    input  logic                  iReset_n,
    input  logic                  iEnable,
    input  logic                  iWrite,
    input  logic [1:0]            iAddr,
    input  logic [15:0]           iWData,
    input  logic                  iQuarterFrame,
    output logic [DATA_WIDTH-1:0] oData,
    output logic                  oStep,
    output logic                  oActive
);
    localparam logic [DATA_WIDTH-1:0] MAX = '1;

    logic [PERIOD_WIDTH-1:0] timer, period;
    logic [LIN_WIDTH-1:0]    linCount, linReload;
    logic                    reloadFlag, halt, down;
    logic [1:0]              mode;
    logic                    tick, step, ctrlWrite, nextDown;
    logic [DATA_WIDTH-1:0]   nextData;

    assign tick      = timer == '0;
    assign step      = iEnable && tick && linCount != '0;
    assign ctrlWrite = iWrite && iAddr == 2'd1;
    assign oActive   = linCount != '0;

    // Modes 1/2 are saws that wrap; modes 0/3 bounce, pausing one step at each end.
    always_comb begin
        nextData = oData;
        nextDown = down;
        if (mode == 2'd1)
            nextData = oData + 1'b1;
        else if (mode == 2'd2)
            nextData = oData - 1'b1;
        else if (!down) begin
            if (oData == MAX) nextDown = 1'b1;
            else              nextData = oData + 1'b1;
        end else begin
            if (oData == '0)  nextDown = 1'b0;
            else              nextData = oData - 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            timer      <= '0;
            period     <= '0;
            linCount   <= '0;
            linReload  <= '0;
            reloadFlag <= 1'b0;
            halt       <= 1'b0;
            mode       <= 2'd0;
            down       <= 1'b0;
            oData      <= '0;
            oStep      <= 1'b0;
        end else begin
            // Timer reloads from the period register as it stood before any write this edge.
            if (iEnable)
                timer <= tick ? period : timer - 1'b1;
            if (step) begin
                oData <= nextData;
                down  <= nextDown;
            end
            oStep <= step;
            if (iQuarterFrame) begin
                if (reloadFlag)
                    linCount <= linReload;
                else if (linCount != '0)
                    linCount <= linCount - 1'b1;
                if (!halt)
                    reloadFlag <= 1'b0;
            end
            if (iWrite && iAddr == 2'd0)
                period <= iWData[PERIOD_WIDTH-1:0];
            // Placed last so a control write overrides the quarter-frame flag clear and the step's direction.
            if (ctrlWrite) begin
                linReload  <= iWData[LIN_WIDTH-1:0];
                mode       <= iWData[14:13];
                halt       <= iWData[15];
                reloadFlag <= 1'b1;
                down       <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_triangle_channel.sv
// tb_triangle_channel: directed, table-driven and randomized checks of triangle_channel against a reference model.
module tb_triangle_channel;
    logic        iClk = 1'b0, iReset_n = 1'b0, iEnable = 1'b0, iWrite = 1'b0, iQuarterFrame = 1'b0;
    logic [1:0]  iAddr = 2'd0;
    logic [15:0] iWData = 16'd0;
    logic [3:0]  oData;
    logic        oStep, oActive;

    int checks = 0, errors = 0;
    int mTimer, mPeriod, mLin, mLinReload, mFlag, mHalt, mMode, mDown, mData, mStep;

    typedef struct {
        int w; int a; int d; int qf; int en;
        int eData; int eStep; int eAct;
    } vec_t;
    vec_t vecs[$];

    triangle_channel dut (
        .iClk(iClk), .iReset_n(iReset_n), .iEnable(iEnable), .iWrite(iWrite),
        .iAddr(iAddr), .iWData(iWData), .iQuarterFrame(iQuarterFrame),
        .oData(oData), .oStep(oStep), .oActive(oActive)
    );

    always #5 iClk = ~iClk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mTimer = 0; mPeriod = 0; mLin = 0; mLinReload = 0; mFlag = 0;
        mHalt = 0; mMode = 0; mDown = 0; mData = 0; mStep = 0;
    endtask

    // One clock edge of the channel, applied in the order its rules demand:
    // wave step and quarter frame see old register values, then writes land.
    task automatic modelEdge(input int w, input int a, input int d, input int qf, input int en);
        int st;
        st = 0;
        if (en != 0) begin
            if (mTimer == 0) begin
                mTimer = mPeriod;
                if (mLin != 0) begin
                    st = 1;
                    if (mMode == 1) mData = (mData + 1) % 16;
                    else if (mMode == 2) mData = (mData + 15) % 16;
                    else if (mDown == 0) begin
                        if (mData == 15) mDown = 1; else mData = mData + 1;
                    end else begin
                        if (mData == 0) mDown = 0; else mData = mData - 1;
                    end
                end
            end else
                mTimer = mTimer - 1;
        end
        if (qf != 0) begin
            if (mFlag != 0) mLin = mLinReload;
            else if (mLin > 0) mLin = mLin - 1;
            if (mHalt == 0) mFlag = 0;
        end
        if (w != 0 && a == 0) mPeriod = d % 2048;
        if (w != 0 && a == 1) begin
            mLinReload = d % 128;
            mMode = (d / 8192) % 4;
            mHalt = d / 32768;
            mFlag = 1;
            mDown = 0;
        end
        mStep = st;
    endtask

    task automatic doCycle(input int w, input int a, input int d, input int qf, input int en);
        iWrite = 1'(w); iAddr = 2'(a); iWData = 16'(d); iQuarterFrame = 1'(qf); iEnable = 1'(en);
        @(posedge iClk);
        modelEdge(w, a, d, qf, en);
        @(negedge iClk);
        chk("model_data", int'(oData), mData);
        chk("model_step", int'(oStep), mStep);
        chk("model_active", int'(oActive), (mLin != 0) ? 1 : 0);
    endtask

    task automatic addVec(input int w, input int a, input int d, input int qf, input int en,
                          input int ed, input int es, input int ea);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.qf = qf; v.en = en; v.eData = ed; v.eStep = es; v.eAct = ea;
        vecs.push_back(v);
    endtask

    initial begin
        int exp26[$];
        int expD, k, bound;
        modelReset();
        repeat (2) @(negedge iClk);
        iReset_n = 1'b1;
        chk("reset_data", int'(oData), 0);
        chk("reset_step", int'(oStep), 0);
        chk("reset_active", int'(oActive), 0);

        // Triangle with a tick every clock
        doCycle(1, 0, 0, 0, 0);
        doCycle(1, 1, 16'h807F, 0, 0);
        chk("tri_pre_active", int'(oActive), 0);
        doCycle(0, 0, 0, 1, 0);
        chk("tri_active", int'(oActive), 1);
        for (int i = 1; i <= 15; i++) exp26.push_back(i);
        exp26.push_back(15);
        for (int i = 14; i >= 0; i--) exp26.push_back(i);
        exp26.push_back(0);
        exp26.push_back(1);
        foreach (exp26[i]) begin
            doCycle(0, 0, 0, 0, 1);
            chk($sformatf("tri_data%0d", i), int'(oData), exp26[i]);
            chk($sformatf("tri_step%0d", i), int'(oStep), 1);
        end
        doCycle(0, 0, 0, 0, 0);
        chk("tri_idle_step", int'(oStep), 0);
        chk("tri_idle_data", int'(oData), 1);

        // Rising saw then falling saw
        doCycle(1, 1, 16'hA07F, 0, 0);
        chk("saw_write_hold", int'(oData), 1);
        expD = 1;
        for (int i = 0; i < 16; i++) begin
            doCycle(0, 0, 0, 0, 1);
            expD = (expD + 1) % 16;
            chk($sformatf("rsaw%0d", i), int'(oData), expD);
        end
        doCycle(1, 1, 16'hC07F, 0, 0);
        for (int i = 0; i < 3; i++) begin
            doCycle(0, 0, 0, 0, 1);
            expD = (expD + 15) % 16;
            chk($sformatf("fsaw%0d", i), int'(oData), expD);
        end

        // Period 3 with an enable gap
        doCycle(1, 0, 3, 0, 0);
        k = 0;
        for (int i = 0; i < 12; i++) begin
            doCycle(0, 0, 0, 0, 1);
            if (k % 4 == 0) expD = (expD + 15) % 16;
            chk($sformatf("per_step%0d", k), int'(oStep), (k % 4 == 0) ? 1 : 0);
            chk($sformatf("per_data%0d", k), int'(oData), expD);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            doCycle(0, 0, 0, 0, 0);
            chk($sformatf("frz_step%0d", i), int'(oStep), 0);
            chk($sformatf("frz_data%0d", i), int'(oData), expD);
        end
        for (int i = 0; i < 4; i++) begin
            doCycle(0, 0, 0, 0, 1);
            if (k % 4 == 0) expD = (expD + 15) % 16;
            chk($sformatf("per_step%0d", k), int'(oStep), (k % 4 == 0) ? 1 : 0);
            chk($sformatf("per_data%0d", k), int'(oData), expD);
            k++;
        end

        // Asynchronous reset while oData = 11
        doCycle(1, 1, 16'hA07F, 0, 0);
        bound = 0;
        while (oData != 4'd11 && bound < 50) begin
            doCycle(0, 0, 0, 0, 1);
            bound++;
        end
        chk("pre_reset_data", int'(oData), 11);
        #2 iReset_n = 1'b0;
        modelReset();
        #1;
        chk("async_data", int'(oData), 0);
        chk("async_step", int'(oStep), 0);
        chk("async_active", int'(oActive), 0);
        @(negedge iClk);
        iReset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            doCycle(0, 0, 0, 1, 1);
            chk($sformatf("silent_step%0d", i), int'(oStep), 0);
            chk($sformatf("silent_active%0d", i), int'(oActive), 0);
        end

        // Linear counter exhaustion, ignored addresses, write/quarter-frame collision
        addVec(1, 0, 16'h0000, 0, 0, 0, 0, 0);
        addVec(1, 1, 16'h0002, 0, 0, 0, 0, 0);
        addVec(0, 0, 0, 1, 0, 0, 0, 1);
        addVec(0, 0, 0, 0, 1, 1, 1, 1);
        addVec(0, 0, 0, 1, 0, 1, 0, 1);
        addVec(0, 0, 0, 1, 0, 1, 0, 0);
        addVec(0, 0, 0, 0, 1, 1, 0, 0);
        addVec(0, 0, 0, 0, 1, 1, 0, 0);
        addVec(1, 2, 16'hFFFF, 0, 0, 1, 0, 0);
        addVec(1, 3, 16'hFFFF, 0, 0, 1, 0, 0);
        addVec(0, 0, 0, 0, 1, 1, 0, 0);
        addVec(0, 0, 0, 1, 0, 1, 0, 0);
        addVec(1, 1, 16'h8009, 0, 0, 1, 0, 0);
        addVec(1, 1, 16'h0005, 1, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) addVec(0, 0, 0, 1, 0, 1, 0, 1);
        addVec(0, 0, 0, 1, 0, 1, 0, 0);
        foreach (vecs[i]) begin
            doCycle(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].qf, vecs[i].en);
            chk($sformatf("vec%0d_data", i), int'(oData), vecs[i].eData);
            chk($sformatf("vec%0d_step", i), int'(oStep), vecs[i].eStep);
            chk($sformatf("vec%0d_active", i), int'(oActive), vecs[i].eAct);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            int w, a, d;
            w = ($urandom_range(0, 7) == 0) ? 1 : 0;
            a = $urandom_range(0, 3);
            d = (a == 0) ? $urandom_range(0, 5) : $urandom_range(0, 65535);
            doCycle(w, a, d, ($urandom_range(0, 9) == 0) ? 1 : 0, ($urandom_range(0, 3) != 0) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
